// File: rtl/tex_share_arb.sv
// Round-robin texture-unit share arbiter with per-requester credits and response routing.
// Optional per-requester stall counters are built when TEX_ARB_PERF_EN is defined.
module tex_share_arb #(
  parameter int NUM_INPUTS    = 4,
  parameter int NUM_LANES     = 4,
  parameter int TAG_WIDTH     = 8,
  parameter int LOD_BITS      = 4,
  parameter int STAGE_BITS    = 1,
  parameter int MAX_PENDING   = 8,
`ifdef TEX_ARB_PERF_EN
  parameter int PERF_CTR_BITS = 32,
`endif
  localparam int IDX_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int OTAG_W = TAG_WIDTH + IDX_W,
  localparam int CW     = 2 * NUM_LANES * 32,
  localparam int LW     = NUM_LANES * LOD_BITS,
  localparam int XW     = NUM_LANES * 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            req_valid_in,
  input  logic [NUM_INPUTS*NUM_LANES-1:0]  req_mask_in,
  input  logic [NUM_INPUTS*CW-1:0]         req_coords_in,
  input  logic [NUM_INPUTS*LW-1:0]         req_lod_in,
  input  logic [NUM_INPUTS*STAGE_BITS-1:0] req_stage_in,
  input  logic [NUM_INPUTS*TAG_WIDTH-1:0]  req_tag_in,
  output logic [NUM_INPUTS-1:0]            req_ready_in,
  output logic                             req_valid_out,
  output logic [NUM_LANES-1:0]             req_mask_out,
  output logic [CW-1:0]                    req_coords_out,
  output logic [LW-1:0]                    req_lod_out,
  output logic [STAGE_BITS-1:0]            req_stage_out,
  output logic [OTAG_W-1:0]                req_tag_out,
  input  logic                             req_ready_out,
  input  logic                             rsp_valid_in,
  input  logic [XW-1:0]                    rsp_texels_in,
  input  logic [OTAG_W-1:0]                rsp_tag_in,
  output logic                             rsp_ready_in,
  output logic [NUM_INPUTS-1:0]            rsp_valid_out,
  output logic [XW-1:0]                    rsp_texels_out,
  output logic [TAG_WIDTH-1:0]             rsp_tag_out,
  input  logic [NUM_INPUTS-1:0]            rsp_ready_out
`ifdef TEX_ARB_PERF_EN
  ,
  output logic [NUM_INPUTS*PERF_CTR_BITS-1:0] perf_stall_cycles
`endif
);

  localparam int PW = $clog2(MAX_PENDING + 1);

  logic [PW-1:0]         r_pend [NUM_INPUTS];
  logic [IDX_W-1:0]      r_rr;
  logic                  r_req_valid;
  logic [NUM_LANES-1:0]  r_mask;
  logic [CW-1:0]         r_coords;
  logic [LW-1:0]         r_lod;
  logic [STAGE_BITS-1:0] r_stage;
  logic [OTAG_W-1:0]     r_otag;
  logic                  r_rsp_valid;
  logic [IDX_W-1:0]      r_rsp_idx;
  logic [XW-1:0]         r_texels;
  logic [TAG_WIDTH-1:0]  r_rsp_tag;

  logic [NUM_INPUTS-1:0] w_elig;
  logic [NUM_INPUTS-1:0] w_rsp_fire;
  logic [IDX_W:0]        w_pos;
  logic [IDX_W-1:0]      w_win;
  logic [IDX_W-1:0]      w_rr_nxt;
  logic                  w_any;
  logic                  w_load;
  logic                  w_rsp_rdy;
  logic                  w_rsp_ok;
  logic                  w_underflow;
  logic [31:0]           w_rsp_idx32;

  logic [NUM_LANES-1:0]  w_sel_mask;
  logic [CW-1:0]         w_sel_coords;
  logic [LW-1:0]         w_sel_lod;
  logic [STAGE_BITS-1:0] w_sel_stage;
  logic [TAG_WIDTH-1:0]  w_sel_tag;

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++)
      w_elig[i] = req_valid_in[i] &&
                  (r_pend[i] < PW'(MAX_PENDING));
  end

  // Scan from the round-robin pointer, wrapping modulo NUM_INPUTS.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_pos = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      w_pos = {1'b0, r_rr} + (IDX_W+1)'(k);
      if (w_pos >= (IDX_W+1)'(NUM_INPUTS))
        w_pos = w_pos - (IDX_W+1)'(NUM_INPUTS);
      if (!w_any && w_elig[w_pos[IDX_W-1:0]]) begin
        w_any = 1'b1;
        w_win = w_pos[IDX_W-1:0];
      end
    end
  end

  assign w_load = !r_req_valid || req_ready_out;

  assign w_rr_nxt = (w_win == IDX_W'(NUM_INPUTS - 1)) ?
                    '0 : w_win + IDX_W'(1);

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++)
      req_ready_in[i] = w_load && w_any &&
                        (w_win == IDX_W'(i));
  end

  always_comb begin
    w_sel_mask   = '0;
    w_sel_coords = '0;
    w_sel_lod    = '0;
    w_sel_stage  = '0;
    w_sel_tag    = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (w_win == IDX_W'(i)) begin
        w_sel_mask   = req_mask_in[i*NUM_LANES +: NUM_LANES];
        w_sel_coords = req_coords_in[i*CW +: CW];
        w_sel_lod    = req_lod_in[i*LW +: LW];
        w_sel_stage  = req_stage_in[i*STAGE_BITS +: STAGE_BITS];
        w_sel_tag    = req_tag_in[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_valid <= 1'b0;
      r_rr        <= '0;
    end else if (w_load) begin
      r_req_valid <= w_any;
      if (w_any)
        r_rr <= w_rr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load && w_any) begin
      r_mask   <= w_sel_mask;
      r_coords <= w_sel_coords;
      r_lod    <= w_sel_lod;
      r_stage  <= w_sel_stage;
      r_otag   <= {w_sel_tag, w_win};
    end
  end

  assign req_valid_out  = r_req_valid;
  assign req_mask_out   = r_mask;
  assign req_coords_out = r_coords;
  assign req_lod_out    = r_lod;
  assign req_stage_out  = r_stage;
  assign req_tag_out    = r_otag;

  assign w_rsp_idx32 = 32'(rsp_tag_in[IDX_W-1:0]);
  assign w_rsp_ok    = w_rsp_idx32 < 32'(NUM_INPUTS);
  assign w_rsp_rdy   = !r_rsp_valid || rsp_ready_out[r_rsp_idx];
  assign rsp_ready_in = w_rsp_rdy;

  // An out-of-range index is consumed but never raises a valid.
  always_ff @(posedge clk) begin
    if (reset)
      r_rsp_valid <= 1'b0;
    else if (w_rsp_rdy)
      r_rsp_valid <= rsp_valid_in && w_rsp_ok;
  end

  always_ff @(posedge clk) begin
    if (w_rsp_rdy && rsp_valid_in) begin
      r_rsp_idx <= rsp_tag_in[IDX_W-1:0];
      r_texels  <= rsp_texels_in;
      r_rsp_tag <= rsp_tag_in[OTAG_W-1:IDX_W];
    end
  end

  always_comb begin
    rsp_valid_out = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      if (r_rsp_valid && (r_rsp_idx == IDX_W'(i)))
        rsp_valid_out[i] = 1'b1;
  end

  assign rsp_texels_out = r_texels;
  assign rsp_tag_out    = r_rsp_tag;
  assign w_rsp_fire     = rsp_valid_out & rsp_ready_out;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (reset) begin
        r_pend[i] <= '0;
      end else begin
        case ({req_ready_in[i], w_rsp_fire[i]})
          2'b10:
            r_pend[i] <= r_pend[i] + PW'(1);
          2'b01:
            if (r_pend[i] != '0)
              r_pend[i] <= r_pend[i] - PW'(1);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_underflow = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++)
      if (w_rsp_fire[i] && !req_ready_in[i] &&
          (r_pend[i] == '0))
        w_underflow = 1'b1;
  end

  a_credit_underflow: assert property (
    @(posedge clk) disable iff (reset) !w_underflow);

  a_rsp_idx_range: assert property (
    @(posedge clk) disable iff (reset)
    !(rsp_valid_in && w_rsp_rdy && !w_rsp_ok));

`ifdef TEX_ARB_PERF_EN
  logic [PERF_CTR_BITS-1:0] r_perf [NUM_INPUTS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (reset)
        r_perf[i] <= '0;
      else if (req_valid_in[i] && !req_ready_in[i])
        r_perf[i] <= r_perf[i] + PERF_CTR_BITS'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++)
      perf_stall_cycles[i*PERF_CTR_BITS +: PERF_CTR_BITS] = r_perf[i];
  end
`endif

endmodule

// File: tb/tb_tex_share_arb.sv
// Randomized plus directed bench for tex_share_arb against a queue-based reference model.
// Checks every cycle at the falling edge; model state commits at the rising edge.
module tb_tex_share_arb;
  localparam int N  = 4;
  localparam int L  = 4;
  localparam int TW = 8;
  localparam int LB = 4;
  localparam int SB = 1;
  localparam int MP = 2;
  localparam int CW = 2 * L * 32;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]    req_valid_in;
  logic [N*L-1:0]  req_mask_in;
  logic [N*CW-1:0] req_coords_in;
  logic [N*L*LB-1:0] req_lod_in;
  logic [N*SB-1:0] req_stage_in;
  logic [N*TW-1:0] req_tag_in;
  logic [N-1:0]    req_ready_in;
  logic            req_valid_out;
  logic [L-1:0]    req_mask_out;
  logic [CW-1:0]   req_coords_out;
  logic [L*LB-1:0] req_lod_out;
  logic [SB-1:0]   req_stage_out;
  logic [TW+1:0]   req_tag_out;
  logic            req_ready_out;
  logic            rsp_valid_in;
  logic [L*32-1:0] rsp_texels_in;
  logic [TW+1:0]   rsp_tag_in;
  logic            rsp_ready_in;
  logic [N-1:0]    rsp_valid_out;
  logic [L*32-1:0] rsp_texels_out;
  logic [TW-1:0]   rsp_tag_out;
  logic [N-1:0]    rsp_ready_out;
`ifdef TEX_ARB_PERF_EN
  logic [N*32-1:0] perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  tex_share_arb #(
    .NUM_INPUTS(N), .NUM_LANES(L), .TAG_WIDTH(TW),
    .LOD_BITS(LB), .STAGE_BITS(SB), .MAX_PENDING(MP)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_mask_in(req_mask_in),
    .req_coords_in(req_coords_in), .req_lod_in(req_lod_in),
    .req_stage_in(req_stage_in), .req_tag_in(req_tag_in),
    .req_ready_in(req_ready_in), .req_valid_out(req_valid_out),
    .req_mask_out(req_mask_out), .req_coords_out(req_coords_out),
    .req_lod_out(req_lod_out), .req_stage_out(req_stage_out),
    .req_tag_out(req_tag_out), .req_ready_out(req_ready_out),
    .rsp_valid_in(rsp_valid_in), .rsp_texels_in(rsp_texels_in),
    .rsp_tag_in(rsp_tag_in), .rsp_ready_in(rsp_ready_in),
    .rsp_valid_out(rsp_valid_out), .rsp_texels_out(rsp_texels_out),
    .rsp_tag_out(rsp_tag_out), .rsp_ready_out(rsp_ready_out)
`ifdef TEX_ARB_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  int pend [N];
  int stall [N];
  int rr;
  bit mv;
  logic [L-1:0]    m_mask;
  logic [CW-1:0]   m_coords;
  logic [L*LB-1:0] m_lod;
  logic [SB-1:0]   m_stage;
  logic [TW+1:0]   m_otag;
  bit rv;
  int ridx;
  logic [L*32-1:0] m_tex;
  logic [TW-1:0]   m_rtag;

  logic [TW+1:0] texq [$];
  int dlog [$];
  int tex_mode;
  int e_win;
  bit e_load;
  bit e_rsp_rdy;
  logic [N-1:0] e_ready;
  logic [N-1:0] d_ready;
  logic [CW-1:0] bp_coords;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      pend[i] = 0;
      stall[i] = 0;
    end
    rr = 0;
    mv = 0;
    rv = 0;
    ridx = 0;
    texq.delete();
  endtask

  task automatic rand_fields();
    req_mask_in = 16'($urandom);
    for (int j = 0; j < N * CW / 32; j++)
      req_coords_in[j*32 +: 32] = $urandom;
    req_lod_in = {$urandom, $urandom};
    req_stage_in = 4'($urandom);
    req_tag_in = $urandom;
  endtask

  // Emulated texture unit: returns accepted requests in order.
  task automatic drive_tex();
    rsp_texels_in = {$urandom, $urandom, $urandom, $urandom};
    rsp_valid_in = 1'b0;
    rsp_tag_in = '0;
    if (texq.size() > 0 &&
        (tex_mode == 2 || (tex_mode == 1 && $urandom_range(0, 2) != 0))) begin
      rsp_valid_in = 1'b1;
      rsp_tag_in = texq[0];
    end
  endtask

  task automatic settle();
    #4;
    e_win = -1;
    e_load = !mv || req_ready_out;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (rr + k) % N;
      if (e_win < 0 && req_valid_in[j] && pend[j] < MP)
        e_win = j;
    end
    e_ready = '0;
    if (e_load && e_win >= 0)
      e_ready[e_win] = 1'b1;
    e_rsp_rdy = !rv || rsp_ready_out[ridx];
    d_ready = req_ready_in;
    chk("req_ready_in", req_ready_in, e_ready);
    chk("req_valid_out", req_valid_out, mv);
    if (mv) begin
      chk("req_mask_out", req_mask_out, m_mask);
      chk("req_coords_out", req_coords_out, m_coords);
      chk("req_lod_out", req_lod_out, m_lod);
      chk("req_stage_out", req_stage_out, m_stage);
      chk("req_tag_out", req_tag_out, m_otag);
    end
    chk("rsp_ready_in", rsp_ready_in, e_rsp_rdy);
    chk("rsp_valid_out", rsp_valid_out, rv ? (4'b0001 << ridx) : 4'b0000);
    if (rv) begin
      chk("rsp_texels_out", rsp_texels_out, m_tex);
      chk("rsp_tag_out", rsp_tag_out, m_rtag);
    end
`ifdef TEX_ARB_PERF_EN
    for (int i = 0; i < N; i++)
      chk("perf_stall", perf_stall_cycles[i*32 +: 32], stall[i]);
`endif
  endtask

  task automatic advance();
    logic [N-1:0] dec;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++)
        if (d_ready[i]) dlog.push_back(i);
      if (mv && req_ready_out) texq.push_back(m_otag);
      if (rsp_valid_in && e_rsp_rdy) void'(texq.pop_front());
      dec = '0;
      if (rv && rsp_ready_out[ridx]) dec[ridx] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (req_valid_in[i] && !e_ready[i]) stall[i]++;
        if (e_ready[i] && !dec[i]) pend[i]++;
        else if (dec[i] && !e_ready[i] && pend[i] > 0) pend[i]--;
      end
      if (e_load) begin
        mv = (e_win >= 0);
        if (e_win >= 0) begin
          m_mask   = req_mask_in[e_win*L +: L];
          m_coords = req_coords_in[e_win*CW +: CW];
          m_lod    = req_lod_in[e_win*L*LB +: L*LB];
          m_stage  = req_stage_in[e_win*SB +: SB];
          m_otag   = {req_tag_in[e_win*TW +: TW], 2'(e_win)};
          rr = (e_win + 1) % N;
        end
      end
      if (e_rsp_rdy) begin
        rv = rsp_valid_in;
        if (rsp_valid_in) begin
          ridx   = int'(rsp_tag_in[1:0]);
          m_tex  = rsp_texels_in;
          m_rtag = rsp_tag_in[TW+1:2];
        end
      end
    end
    #1;
  endtask

  task automatic cyc();
    drive_tex();
    settle();
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid_in = '0;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid_in = '0;
    rand_fields();
    req_ready_out = 1'b1;
    rsp_valid_in = 1'b0;
    rsp_texels_in = '0;
    rsp_tag_in = '0;
    rsp_ready_out = '1;
    tex_mode = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid_out", req_valid_out, 0);
    chk("rst_rsp_valid_out", rsp_valid_out, 0);
    chk("rst_rsp_ready_in", rsp_ready_in, 1);
    chk("rst_req_ready_in", req_ready_in, 0);
    reset = 1'b0;

    // Fairness: everyone valid, credits allow two grants each.
    req_valid_in = '1;
    dlog.delete();
    repeat (10) begin
      rand_fields();
      cyc();
    end
    chk("fair_count", dlog.size(), 8);
    for (int k = 0; k < 8 && k < dlog.size(); k++)
      chk("fair_order", dlog[k], k % 4);

    // Credit limit on requester 1, then one credit returned.
    do_reset();
    req_valid_in = 4'b0010;
    dlog.delete();
    repeat (5) begin
      rand_fields();
      cyc();
    end
    chk("credit_accepts", dlog.size(), 2);
    tex_mode = 2;
    cyc();
    tex_mode = 0;
    drive_tex();
    settle();
    chk("credit_blocked", req_ready_in[1], 0);
    chk("credit_rsp_route", rsp_valid_out, 4'b0010);
    advance();
    drive_tex();
    settle();
    chk("credit_freed", req_ready_in[1], 1);
    advance();

    // Backpressure on the request stage.
    do_reset();
    req_valid_in = 4'b0100;
    req_ready_out = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_fields();
      drive_tex();
      settle();
      chk("bp_ready", req_ready_in[2], k == 0);
      if (k == 1) bp_coords = req_coords_out;
      if (k > 1) chk("bp_stable", req_coords_out, bp_coords);
      advance();
    end
    req_ready_out = 1'b1;
    cyc();

    // Response routing to requester 3 with a held ready.
    do_reset();
    rand_fields();
    req_tag_in[3*TW +: TW] = 8'hA5;
    req_valid_in = 4'b1000;
    cyc();
    req_valid_in = '0;
    cyc();
    tex_mode = 2;
    rsp_ready_out = 4'b0111;
    cyc();
    tex_mode = 0;
    for (int k = 0; k < 3; k++) begin
      drive_tex();
      settle();
      chk("route_valid", rsp_valid_out, 4'b1000);
      chk("route_tag", rsp_tag_out, 8'hA5);
      chk("route_held", rsp_ready_in, 0);
      advance();
    end
    rsp_ready_out = '1;
    drive_tex();
    settle();
    chk("route_release", rsp_ready_in, 1);
    advance();
    cyc();

    // Accept and response fire for requester 0 in the same cycle.
    do_reset();
    req_valid_in = 4'b0001;
    rand_fields();
    cyc();
    req_valid_in = '0;
    cyc();
    tex_mode = 2;
    cyc();
    tex_mode = 0;
    req_valid_in = 4'b0001;
    rand_fields();
    drive_tex();
    settle();
    chk("simul_accept", req_ready_in[0], 1);
    chk("simul_fire", rsp_valid_out[0] & rsp_ready_out[0], 1);
    advance();
    dlog.delete();
    repeat (4) begin
      rand_fields();
      cyc();
    end
    chk("simul_credit", dlog.size(), 1);

    // Reset with requests in flight.
    req_valid_in = 4'b1110;
    repeat (3) begin
      rand_fields();
      cyc();
    end
    reset = 1'b1;
    req_valid_in = '1;
    cyc();
    reset = 1'b0;
    drive_tex();
    settle();
    chk("mid_rst_req_valid", req_valid_out, 0);
    chk("mid_rst_rsp_valid", rsp_valid_out, 0);
    chk("mid_rst_rsp_ready", rsp_ready_in, 1);
    chk("mid_rst_grant", req_ready_in, 4'b0001);
`ifdef TEX_ARB_PERF_EN
    chk("mid_rst_perf", perf_stall_cycles, 0);
`endif
    advance();

    tex_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      req_valid_in = 4'($urandom) | 4'($urandom);
      rand_fields();
      req_ready_out = ($urandom_range(0, 3) != 0);
      rsp_ready_out = 4'($urandom) | 4'($urandom);
      cyc();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tex_share_arb.md
# tex_share_arb

Round-robin request arbiter and response router that shares one texture unit among `NUM_INPUTS` requesters (cores or sockets). It sits in front of the texture unit's request/response bus. It appends the winning requester index to the tag and steers each response back to its originator by that index. Per-requester credit counters cap the requests each requester may have in flight, so a single requester cannot fill the unit's internal pipeline.

## Interface
Parameters:
- `NUM_INPUTS`, 4, number of requesters (≥1).
- `NUM_LANES`, 4, lanes per request.
- `TAG_WIDTH`, 8, requester tag width.
- `LOD_BITS`, 4, per-lane LOD field width.
- `STAGE_BITS`, 1, texture stage select width.
- `MAX_PENDING`, 8, in-flight requests allowed per requester (≥1).
- Derived: `IDX_W` = max(1, clog2(`NUM_INPUTS`)); `OTAG_W` = `TAG_WIDTH` + `IDX_W`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid_in`  in  `NUM_INPUTS`  per-requester request valid.
- `req_mask_in`  in  `NUM_INPUTS`×`NUM_LANES`  lane masks.
- `req_coords_in`  in  `NUM_INPUTS`×2×`NUM_LANES`×32  u/v coordinates.
- `req_lod_in`  in  `NUM_INPUTS`×`NUM_LANES`×`LOD_BITS`  LODs.
- `req_stage_in`  in  `NUM_INPUTS`×`STAGE_BITS`  stage.
- `req_tag_in`  in  `NUM_INPUTS`×`TAG_WIDTH`  tags.
- `req_ready_in`  out  `NUM_INPUTS`  per-requester accept.
- `req_valid_out`, `req_mask_out`, `req_coords_out`, `req_lod_out`, `req_stage_out`  out  single-requester widths  request to the texture unit.
- `req_tag_out`  out  `OTAG_W`  tag = {requester tag, index}, with the index in the LSBs.
- `req_ready_out`  in  1  texture unit accept.
- `rsp_valid_in`  in  1  texture unit response valid.
- `rsp_texels_in`  in  `NUM_LANES`×32  texels.
- `rsp_tag_in`  in  `OTAG_W`  returned tag.
- `rsp_ready_in`  out  1  response accept.
- `rsp_valid_out`  out  `NUM_INPUTS`  per-requester response valid (one-hot or zero).
- `rsp_texels_out`  out  `NUM_LANES`×32  texels, shared across requesters.
- `rsp_tag_out`  out  `TAG_WIDTH`  original tag, shared across requesters.
- `rsp_ready_out`  in  `NUM_INPUTS`  per-requester response accept.

## Operation
- **Eligibility:** requester i is eligible when `req_valid_in[i]` is high and `pending[i]` < `MAX_PENDING`.
- **Arbitration:** round-robin starting at pointer `rr`.
  - The winner is the first eligible index at or after `rr`, wrapping modulo `NUM_INPUTS`.
  - Arbitration is evaluated only when the output stage can load.
- **Request output stage:** a single registered stage; load condition is `!req_valid_out || req_ready_out`.
  - `req_ready_in[i]` = winner==i && load condition && any eligible. At most one bit is high per cycle.
  - On accept: the stage loads the winner's fields with tag {tag, i}, and `rr` ← (i+1) mod `NUM_INPUTS`.
  - With no eligible requester and the stage draining, `req_valid_out` drops and `rr` holds.
- **Credits:** `pending[i]` is clog2(`MAX_PENDING`+1) bits wide.
  - +1 on request accept from requester i.
  - −1 on `rsp_valid_out[i] && rsp_ready_out[i]`.
  - Both events in the same cycle: unchanged.
  - A decrement at 0 is a protocol error: simulation assertion, counter saturates at 0.
- **Response stage:** a single registered stage; `rsp_ready_in` = `!rsp_valid_any || rsp_ready_out[idx_reg]`.
  - On load it captures the texels, `tag[OTAG_W-1:IDX_W]` and `idx` = `tag[IDX_W-1:0]`.
  - `rsp_valid_out` = valid_reg ? (1<<idx_reg) : 0.
  - An index ≥ `NUM_INPUTS`: assertion; the response is dropped (consumed, no valid raised).
- **Response ordering:** responses are routed in arrival order. No per-requester reordering.
- **`NUM_INPUTS`=1:** `IDX_W`=1, index always 0; the block behaves as a 1-deep pipe with credit limiting.

## Timing
- **Reset:** all `req_valid_out`/`rsp_valid_out` = 0, `req_ready_in` = 0 (combinationally, because no input is eligible while `req_valid_in` is low), `rsp_ready_in` = 1, `pending` = 0, `rr` = 0. Data outputs are don't-care.
- **Reset mid-operation:** in-flight requests and credits are discarded. The texture unit must be reset in the same cycle.
- **Request latency:** 1 cycle from accept to `req_valid_out`.
  - Full throughput: one request per cycle when `req_ready_out` stays high.
  - Under backpressure, stage contents stay stable until `req_ready_out`.
- **Response latency:** 1 cycle; one response per cycle when the addressed requester is ready.
- **Ready dependencies:** `req_ready_in` depends combinationally on `req_valid_in`, `pending`, `req_ready_out`. `rsp_ready_in` depends combinationally on `rsp_ready_out`.
- **Credit timing:** a credit freed in cycle t makes the requester eligible in cycle t+1.

## Configuration
- `TEX_ARB_PERF_EN` defined:
  - Adds output `perf_stall_cycles` (`NUM_INPUTS`×`PERF_CTR_BITS`), one counter per requester.
  - Counter i increments each cycle `req_valid_in[i] && !req_ready_in[i]`; reset to 0.
- `TEX_ARB_PERF_EN` undefined: port and counters absent; functional behaviour identical.

## Test plan
- **Fairness:** `NUM_INPUTS`=4, all requesters valid continuously, `req_ready_out`=1 → grant order 0,1,2,3,0,…; each `req_tag_out[1:0]` equals its grant index.
- **Credit limit:** `MAX_PENDING`=2, requester 1 valid only, no responses → exactly 2 accepts, then `req_ready_in[1]`=0. One response with tag index 1 is accepted → third accept on the following cycle.
- **Backpressure:** `req_ready_out`=0 for 5 cycles with requester 2 valid → `req_valid_out` held with stable data. `req_ready_in[2]`=1 only in the cycle the stage is empty.
- **Response routing:** `rsp_tag_in`={8'hA5, 2'd3} → `rsp_valid_out`=4'b1000, `rsp_tag_out`=8'hA5. With `rsp_ready_out[3]`=0, `rsp_ready_in` stays 0 until it rises.
- **Simultaneous credit events:** requester 0 has a request accept and a response fire in the same cycle → `pending[0]` unchanged.
- **Reset mid-operation:** reset asserted with 3 requests pending → next cycle all valids 0, `pending` 0, `rr` 0; `perf_stall_cycles` 0 when `TEX_ARB_PERF_EN` is defined.
